alarm_sequencer: RTL and testbench
==================================

Name: alarm_sequencer

Overview:
- Control FSM for the alarm clock.
- Sequences alarm-time entry and current-time entry from two push-buttons.
- Compares the running BCD time against the stored alarm time, then drives the ring/snooze/dismiss cycle.
- Sits between the BCD minute/hour counters, the switches/buttons, the LCD controller (display select) and the audio gate (ring).

Parameters:
- ALARM_DEFAULT, 16'h0700: reset value of alarm_time, BCD {h1,h0,m1,m0}.
- SNOOZE_MIN, 5: snooze length in minutes (1..15).
- RING_TIMEOUT_S, 60: seconds of ringing before auto-dismiss (1..255).
- MAX_SNOOZE, 3: snooze limit; used only with SNOOZE_LIMIT_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- tick_1s  in  1  one-clk pulse per second.
- cur_time  in  16  running time, BCD {h1,h0,m1,m0}.
- alarm_en  in  1  alarm enable switch (level).
- btn_mode  in  1  debounced one-clk pulse.
- btn_inc  in  1  debounced one-clk pulse.
- btn_snooze  in  1  debounced one-clk pulse.
- alarm_time  out  16  stored alarm time, BCD.
- set_time  out  16  time value to load into the counters, BCD.
- set_load  out  1  one-clk strobe: counters load set_time.
- ring  out  1  alarm sounding.
- disp_sel  out  2  0 = cur_time, 1 = alarm_time, 2 = set_time.
- state_o  out  3  current FSM state, for debug.

Behaviour:
- Reset (asynchronous, rst=1) forces:
  - state IDLE; alarm_time=ALARM_DEFAULT; set_time=0; set_load=0; ring=0; disp_sel=0.
  - fired=0; all counters 0.
- All state/registers update on the clk rising edge. Every input causes its effect one clk later.
- Outputs decode the registered state:
  - ring=1 iff state==RING.
  - disp_sel=1 in SET_AH/SET_AM; 2 in SET_TH/SET_TM; else 0.
- State encodings: IDLE=0, SET_AH=1, SET_AM=2, SET_TH=3, SET_TM=4, RING=5, SNOOZE=6.
- match = alarm_en & (cur_time==alarm_time).
- fired flag:
  - Set on entry to RING.
  - Cleared whenever cur_time!=alarm_time.
  - Prevents re-ringing within the same minute after a dismiss.
- IDLE:
  - If match & !fired: go to RING. This takes priority over btn_mode in the same cycle.
  - Else if btn_mode: go to SET_AH.
- SET_AH:
  - btn_inc advances alarm hours through BCD 00..23. 09->10, 19->20, 23->00. Minutes are untouched.
  - btn_mode: go to SET_AM.
- SET_AM:
  - btn_inc advances alarm minutes through 00..59. 09->10, 59->00. No carry into hours.
  - btn_mode: go to SET_TH, and copy cur_time into set_time.
- SET_TH / SET_TM:
  - btn_inc steps the hours / minutes of set_time, with the same wrap rules.
  - btn_mode in SET_TM: go to IDLE, with set_load=1 for exactly one clk.
- btn_inc and btn_mode in the same cycle: mode wins; no increment.
- Alarm match is ignored during SET_* states. fired is not set, so a still-matching minute rings on return to IDLE.
- RING:
  - On entry, the ring timer loads 0.
  - Each tick_1s increments the timer. Reaching RING_TIMEOUT_S: go to IDLE.
  - btn_mode, or alarm_en=0: go to IDLE (dismiss).
  - btn_snooze: go to SNOOZE, loading the snooze counter with SNOOZE_MIN*60 (10-bit).
  - Priority: alarm_en=0 > btn_mode > btn_snooze > timeout.
- SNOOZE:
  - Each tick_1s decrements the snooze counter. When it is 1 and a tick arrives: go to RING, with the ring timer reset.
  - btn_mode or alarm_en=0: go to IDLE.
  - btn_snooze is ignored.
- alarm_en toggling outside RING/SNOOZE only affects match.
- Reset mid-ring or mid-set: immediate IDLE; partially entered set_time is discarded; no set_load.

Optional Feature:
- SNOOZE_LIMIT_EN defined:
  - A 2-bit-minimum snooze count increments on each RING->SNOOZE transition and clears on entry to IDLE.
  - In RING with count==MAX_SNOOZE, btn_snooze acts as dismiss (go to IDLE).
- Undefined: unlimited snoozes; no counter logic is synthesised.

Test Plan:
1. Reset with ALARM_DEFAULT=16'h0700; drive cur_time=16'h0700, alarm_en=1 -> ring=1 one clk later, state_o=5; btn_mode -> ring=0 next clk; no re-ring while cur_time stays 0700; cur_time 0701 then back to 0700 -> rings again.
2. From IDLE:
   - btn_mode, then btn_inc x17 -> alarm hours 07->23->00 across 09->10 and 19->20.
   - btn_mode, then btn_inc x60 -> minutes return to 00.
   - disp_sel=1 throughout.
3. Time set with cur_time=16'h1259:
   - Enter SET_TH -> set_time=16'h1259.
   - btn_inc x2 in SET_TH -> set_time=16'h1459.
   - btn_mode -> SET_TM.
   - btn_inc -> set_time=16'h1400.
   - btn_mode -> set_load high exactly 1 clk, then disp_sel=0.
4. SNOOZE_MIN=1:
   - Ring, then btn_snooze -> ring=0.
   - After 60 tick_1s -> ring=1.
   - Then 60 ticks (RING_TIMEOUT_S) with no buttons -> IDLE.
5. In RING, btn_mode and btn_snooze in the same clk -> IDLE (not SNOOZE). In SNOOZE, drop alarm_en -> IDLE. Assert rst mid-SET_TM -> IDLE, set_load stays 0.
6. With SNOOZE_LIMIT_EN and MAX_SNOOZE=3 -> the 4th btn_snooze dismisses to IDLE. Without the macro -> it enters SNOOZE.

Source files
------------

// File: rtl/alarm_sequencer_if.sv
// alarm_sequencer_if
//   Signal bundle between the alarm sequencer and its neighbours.
//   master : drives time/button inputs, observes sequencer outputs
//   slave  : the sequencer itself
//   Signals:
//     tick_1s     one-clk pulse per second
//     cur_time    running time, BCD {h1,h0,m1,m0}
//     alarm_en    alarm enable switch (level)
//     btn_mode    debounced one-clk pulse
//     btn_inc     debounced one-clk pulse
//     btn_snooze  debounced one-clk pulse
//     alarm_time  stored alarm time, BCD
//     set_time    value for the counters to load, BCD
//     set_load    one-clk load strobe for the counters
//     ring        alarm sounding
//     disp_sel    0 = cur_time, 1 = alarm_time, 2 = set_time
//     state_o     current FSM state (debug)
interface alarm_sequencer_if;
    logic        tick_1s;
    logic [15:0] cur_time;
    logic        alarm_en;
    logic        btn_mode;
    logic        btn_inc;
    logic        btn_snooze;
    logic [15:0] alarm_time;
    logic [15:0] set_time;
    logic        set_load;
    logic        ring;
    logic [1:0]  disp_sel;
    logic [2:0]  state_o;

    modport master (
        output tick_1s, cur_time, alarm_en, btn_mode, btn_inc, btn_snooze,
        input  alarm_time, set_time, set_load, ring, disp_sel, state_o
    );

    modport slave (
        input  tick_1s, cur_time, alarm_en, btn_mode, btn_inc, btn_snooze,
        output alarm_time, set_time, set_load, ring, disp_sel, state_o
    );
endinterface

// File: rtl/alarm_sequencer.sv
// alarm_sequencer
//   Control FSM for the alarm clock: alarm-time entry, current-time entry,
//   alarm match, and the ring / snooze / dismiss cycle.
//   Ports:
//     clk  system clock
//     rst  asynchronous, active-high reset
//     bus  alarm_sequencer_if.slave (time, switches, buttons in;
//          alarm_time, set_time, set_load, ring, disp_sel, state_o out)
//   Parameters:
//     ALARM_DEFAULT   reset value of alarm_time (BCD hhmm)
//     SNOOZE_MIN      snooze length in minutes (1..15)
//     RING_TIMEOUT_S  seconds of ringing before auto-dismiss (1..255)
//     MAX_SNOOZE      snooze limit (only with SNOOZE_LIMIT_EN)
//   Optional feature macro: SNOOZE_LIMIT_EN
//     defined   : snoozes per alarm are counted; once MAX_SNOOZE is reached
//                 btn_snooze dismisses instead of snoozing
//     undefined : unlimited snoozes, no counter
module alarm_sequencer #(
    parameter logic [15:0] ALARM_DEFAULT  = 16'h0700,
    parameter int unsigned SNOOZE_MIN     = 5,
    parameter int unsigned RING_TIMEOUT_S = 60,
    parameter int unsigned MAX_SNOOZE     = 3
) (
    input  logic              clk,
    input  logic              rst,
    alarm_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SET_AH = 3'd1,
        SET_AM = 3'd2,
        SET_TH = 3'd3,
        SET_TM = 3'd4,
        RING   = 3'd5,
        SNOOZE = 3'd6
    } state_t;

    localparam logic [9:0] SNOOZE_LOAD = 10'(SNOOZE_MIN * 60);
    localparam logic [7:0] RING_LAST   = 8'(RING_TIMEOUT_S - 1);

    state_t      state, state_nxt;
    logic [15:0] alarm_q;
    logic [15:0] set_q;
    logic        set_load_q;
    logic        ring_q;
    logic [1:0]  disp_q;
    logic        fired;
    logic [7:0]  ring_tmr;
    logic [9:0]  snz_cnt;
    logic        match;
    logic        snz_exhausted;

    // BCD hours 00..23, wrapping to 00 (also recovers from out-of-range input)
    function automatic logic [7:0] bcd_inc_hour(input logic [7:0] h);
        if (h >= 8'h23)
            return 8'h00;
        else if (h[3:0] >= 4'd9)
            return {h[7:4] + 4'd1, 4'd0};
        else
            return {h[7:4], h[3:0] + 4'd1};
    endfunction

    // BCD minutes 00..59, wrapping to 00 with no carry out
    function automatic logic [7:0] bcd_inc_min(input logic [7:0] m);
        if (m >= 8'h59)
            return 8'h00;
        else if (m[3:0] >= 4'd9)
            return {m[7:4] + 4'd1, 4'd0};
        else
            return {m[7:4], m[3:0] + 4'd1};
    endfunction

    assign match = bus.alarm_en && (bus.cur_time == alarm_q);

`ifdef SNOOZE_LIMIT_EN
    localparam int unsigned SC_W = (MAX_SNOOZE > 3) ? $clog2(MAX_SNOOZE + 1) : 2;
    logic [SC_W-1:0] snz_num;
    assign snz_exhausted = (snz_num == SC_W'(MAX_SNOOZE));
`else
    assign snz_exhausted = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                // an alarm match outranks a mode press in the same cycle
                if (match && !fired)
                    state_nxt = RING;
                else if (bus.btn_mode)
                    state_nxt = SET_AH;
            end
            SET_AH: if (bus.btn_mode) state_nxt = SET_AM;
            SET_AM: if (bus.btn_mode) state_nxt = SET_TH;
            SET_TH: if (bus.btn_mode) state_nxt = SET_TM;
            SET_TM: if (bus.btn_mode) state_nxt = IDLE;
            RING: begin
                if (!bus.alarm_en || bus.btn_mode)
                    state_nxt = IDLE;
                else if (bus.btn_snooze)
                    state_nxt = snz_exhausted ? IDLE : SNOOZE;
                else if (bus.tick_1s && ring_tmr == RING_LAST)
                    state_nxt = IDLE;
            end
            SNOOZE: begin
                if (!bus.alarm_en || bus.btn_mode)
                    state_nxt = IDLE;
                else if (bus.tick_1s && snz_cnt == 10'd1)
                    state_nxt = RING;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            alarm_q    <= ALARM_DEFAULT;
            set_q      <= '0;
            set_load_q <= 1'b0;
            ring_q     <= 1'b0;
            disp_q     <= '0;
            fired      <= 1'b0;
            ring_tmr   <= '0;
            snz_cnt    <= '0;
`ifdef SNOOZE_LIMIT_EN
            snz_num    <= '0;
`endif
        end else begin
            state <= state_nxt;

            // outputs are registered from the next state so they line up
            // with state_o in the same cycle
            ring_q     <= (state_nxt == RING);
            set_load_q <= (state == SET_TM) && (state_nxt == IDLE);
            case (state_nxt)
                SET_AH, SET_AM: disp_q <= 2'd1;
                SET_TH, SET_TM: disp_q <= 2'd2;
                default:        disp_q <= 2'd0;
            endcase

            // mode wins over inc in the same cycle
            if (bus.btn_inc && !bus.btn_mode) begin
                case (state)
                    SET_AH:  alarm_q[15:8] <= bcd_inc_hour(alarm_q[15:8]);
                    SET_AM:  alarm_q[7:0]  <= bcd_inc_min(alarm_q[7:0]);
                    SET_TH:  set_q[15:8]   <= bcd_inc_hour(set_q[15:8]);
                    SET_TM:  set_q[7:0]    <= bcd_inc_min(set_q[7:0]);
                    default: ;
                endcase
            end

            if (state == SET_AM && bus.btn_mode)
                set_q <= bus.cur_time;

            // entering RING marks the minute as used; any minute change re-arms
            if (state_nxt == RING && state != RING)
                fired <= 1'b1;
            else if (bus.cur_time != alarm_q)
                fired <= 1'b0;

            if (state_nxt == RING && state != RING)
                ring_tmr <= '0;
            else if (state == RING && bus.tick_1s)
                ring_tmr <= ring_tmr + 8'd1;

            if (state == RING && state_nxt == SNOOZE)
                snz_cnt <= SNOOZE_LOAD;
            else if (state == SNOOZE && bus.tick_1s && snz_cnt != '0)
                snz_cnt <= snz_cnt - 10'd1;

`ifdef SNOOZE_LIMIT_EN
            if (state_nxt == IDLE && state != IDLE)
                snz_num <= '0;
            else if (state == RING && state_nxt == SNOOZE)
                snz_num <= snz_num + 1'b1;
`endif
        end
    end

    assign bus.alarm_time = alarm_q;
    assign bus.set_time   = set_q;
    assign bus.set_load   = set_load_q;
    assign bus.ring       = ring_q;
    assign bus.disp_sel   = disp_q;
    assign bus.state_o    = state;

endmodule

// File: tb/tb_alarm_sequencer.sv
// tb_alarm_sequencer
//   Directed walk through the alarm sequencer's behaviours, followed by a
//   randomized run, all checked against a time-in-integers reference model.
module tb_alarm_sequencer;

    localparam int SNOOZE_MIN     = 1;
    localparam int RING_TIMEOUT_S = 60;
    localparam int MAX_SNOOZE     = 3;
`ifdef SNOOZE_LIMIT_EN
    localparam bit LIMIT = 1'b1;
`else
    localparam bit LIMIT = 1'b0;
`endif

    // model states (numbers as seen on state_o)
    localparam int M_IDLE = 0, M_AH = 1, M_AM = 2, M_TH = 3, M_TM = 4, M_RING = 5, M_SNZ = 6;

    logic clk;
    logic rst;
    alarm_sequencer_if bus();

    alarm_sequencer #(
        .ALARM_DEFAULT(16'h0700),
        .SNOOZE_MIN(SNOOZE_MIN),
        .RING_TIMEOUT_S(RING_TIMEOUT_S),
        .MAX_SNOOZE(MAX_SNOOZE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // stimulus levels
    int cur_h, cur_m;
    bit en;

    // reference model
    int  m_st;
    int  a_h, a_m, s_h, s_m;
    bit  m_fired, m_load;
    int  ring_secs, snooze_left, snoozes;

    function automatic logic [15:0] bcd(input int h, input int m);
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = M_IDLE; a_h = 7; a_m = 0; s_h = 0; s_m = 0;
        m_fired = 0; m_load = 0; ring_secs = 0; snooze_left = 0; snoozes = 0;
    endtask

    task automatic model_edge(input bit mode, input bit inc, input bit snz, input bit tick);
        int nst;
        bit same;
        nst = m_st;
        m_load = 0;
        same = (cur_h == a_h) && (cur_m == a_m);
        case (m_st)
            M_IDLE: if (en && same && !m_fired) nst = M_RING; else if (mode) nst = M_AH;
            M_AH:   if (mode) nst = M_AM; else if (inc) a_h = (a_h + 1) % 24;
            M_AM:   if (mode) begin nst = M_TH; s_h = cur_h; s_m = cur_m; end
                    else if (inc) a_m = (a_m + 1) % 60;
            M_TH:   if (mode) nst = M_TM; else if (inc) s_h = (s_h + 1) % 24;
            M_TM:   if (mode) begin nst = M_IDLE; m_load = 1; end
                    else if (inc) s_m = (s_m + 1) % 60;
            M_RING: begin
                if (!en || mode) nst = M_IDLE;
                else if (snz) begin
                    if (LIMIT && snoozes == MAX_SNOOZE) nst = M_IDLE;
                    else begin
                        nst = M_SNZ;
                        snooze_left = SNOOZE_MIN * 60;
                        snoozes++;
                    end
                end else if (tick) begin
                    ring_secs++;
                    if (ring_secs == RING_TIMEOUT_S) nst = M_IDLE;
                end
            end
            M_SNZ: begin
                if (!en || mode) nst = M_IDLE;
                else if (tick) begin
                    snooze_left--;
                    if (snooze_left == 0) nst = M_RING;
                end
            end
            default: nst = M_IDLE;
        endcase
        if (!same) m_fired = 0;
        if (nst == M_RING && m_st != M_RING) begin
            m_fired = 1;
            ring_secs = 0;
        end
        if (nst == M_IDLE && m_st != M_IDLE) snoozes = 0;
        m_st = nst;
    endtask

    task automatic check_all(input string tag);
        logic [15:0] exp_disp;
        exp_disp = (m_st == M_AH || m_st == M_AM) ? 16'd1 :
                   (m_st == M_TH || m_st == M_TM) ? 16'd2 : 16'd0;
        chk({tag, "_state"},    16'(bus.state_o),  16'(m_st));
        chk({tag, "_ring"},     16'(bus.ring),     16'(m_st == M_RING));
        chk({tag, "_disp"},     16'(bus.disp_sel), exp_disp);
        chk({tag, "_alarm"},    bus.alarm_time,    bcd(a_h, a_m));
        chk({tag, "_set_time"}, bus.set_time,      bcd(s_h, s_m));
        chk({tag, "_set_load"}, 16'(bus.set_load), 16'(m_load));
    endtask

    task automatic step(input string tag, input bit mode, input bit inc, input bit snz, input bit tick);
        bus.btn_mode   = mode;
        bus.btn_inc    = inc;
        bus.btn_snooze = snz;
        bus.tick_1s    = tick;
        bus.alarm_en   = en;
        bus.cur_time   = bcd(cur_h, cur_m);
        @(posedge clk);
        model_edge(mode, inc, snz, tick);
        #1;
        check_all(tag);
        bus.btn_mode   = 1'b0;
        bus.btn_inc    = 1'b0;
        bus.btn_snooze = 1'b0;
        bus.tick_1s    = 1'b0;
    endtask

    initial begin
        bit r_mode, r_inc, r_snz, r_tick;

        rst = 1'b1;
        en = 1'b1; cur_h = 7; cur_m = 0;
        bus.tick_1s = 1'b0; bus.btn_mode = 1'b0; bus.btn_inc = 1'b0; bus.btn_snooze = 1'b0;
        bus.alarm_en = 1'b1; bus.cur_time = 16'h0700;
        model_reset();
        #12;
        chk("rst_state", 16'(bus.state_o), 16'd0);
        chk("rst_alarm", bus.alarm_time, 16'h0700);
        chk("rst_set_time", bus.set_time, 16'h0000);
        chk("rst_ring", 16'(bus.ring), 16'd0);
        chk("rst_disp", 16'(bus.disp_sel), 16'd0);
        chk("rst_set_load", 16'(bus.set_load), 16'd0);
        rst = 1'b0;

        // 1: ring, dismiss, no re-ring in the same minute, re-ring after minute change
        step("t1_match", 0, 0, 0, 0);
        chk("t1_ring_on", 16'(bus.ring), 16'd1);
        chk("t1_state_ring", 16'(bus.state_o), 16'd5);
        step("t1_dismiss", 1, 0, 0, 0);
        chk("t1_ring_off", 16'(bus.ring), 16'd0);
        repeat (3) step("t1_hold", 0, 0, 0, 0);
        chk("t1_no_rering", 16'(bus.ring), 16'd0);
        cur_m = 1; step("t1_0701", 0, 0, 0, 0);
        cur_m = 0; step("t1_0700", 0, 0, 0, 0);
        chk("t1_rering", 16'(bus.ring), 16'd1);
        step("t1_dismiss2", 1, 0, 0, 0);

        // 2: alarm hours and minutes entry
        cur_h = 12; cur_m = 59;
        step("t2_enter", 1, 0, 0, 0);
        repeat (17) step("t2_hinc", 0, 1, 0, 0);
        chk("t2_hours_wrap", bus.alarm_time, 16'h0000);
        step("t2_to_am", 1, 0, 0, 0);
        repeat (60) step("t2_minc", 0, 1, 0, 0);
        chk("t2_min_wrap", bus.alarm_time, 16'h0000);
        step("t2_mode_inc", 1, 1, 0, 0);

        // 3: time entry starting from 12:59
        chk("t3_copy", bus.set_time, 16'h1259);
        repeat (2) step("t3_hinc", 0, 1, 0, 0);
        chk("t3_hours", bus.set_time, 16'h1459);
        step("t3_to_tm", 1, 0, 0, 0);
        step("t3_minc", 0, 1, 0, 0);
        chk("t3_min_wrap", bus.set_time, 16'h1400);
        step("t3_load", 1, 0, 0, 0);
        chk("t3_set_load_hi", 16'(bus.set_load), 16'd1);
        step("t3_after", 0, 0, 0, 0);
        chk("t3_set_load_lo", 16'(bus.set_load), 16'd0);
        chk("t3_disp_cur", 16'(bus.disp_sel), 16'd0);

        // 4: snooze then timeout (alarm is now 00:00)
        cur_h = 0; cur_m = 0;
        step("t4_ring", 0, 0, 0, 0);
        step("t4_snooze", 0, 0, 1, 0);
        chk("t4_snooze_quiet", 16'(bus.ring), 16'd0);
        repeat (59) step("t4_snz_tick", 0, 0, 0, 1);
        chk("t4_still_snoozing", 16'(bus.ring), 16'd0);
        step("t4_snz_end", 0, 0, 0, 1);
        chk("t4_rering", 16'(bus.ring), 16'd1);
        repeat (59) step("t4_ring_tick", 0, 0, 0, 1);
        chk("t4_before_timeout", 16'(bus.state_o), 16'd5);
        step("t4_timeout", 0, 0, 0, 1);
        chk("t4_timed_out", 16'(bus.state_o), 16'd0);
        step("t4_no_rering", 0, 0, 0, 0);

        // 5: priority, alarm_en drop in snooze, reset mid-set
        cur_m = 1; step("t5_clr", 0, 0, 0, 0);
        cur_m = 0; step("t5_ring", 0, 0, 0, 0);
        step("t5_mode_snz", 1, 0, 1, 0);
        chk("t5_mode_wins", 16'(bus.state_o), 16'd0);
        cur_m = 1; step("t5_clr2", 0, 0, 0, 0);
        cur_m = 0; step("t5_ring2", 0, 0, 0, 0);
        step("t5_snooze", 0, 0, 1, 0);
        en = 1'b0; step("t5_en_drop", 0, 0, 0, 0);
        chk("t5_en_idle", 16'(bus.state_o), 16'd0);
        en = 1'b1; cur_h = 12; cur_m = 0;
        repeat (4) step("t5_to_tm", 1, 0, 0, 0);
        step("t5_tm_inc", 0, 1, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_state", 16'(bus.state_o), 16'd0);
        chk("t5_rst_set_load", 16'(bus.set_load), 16'd0);
        chk("t5_rst_set_time", bus.set_time, 16'h0000);
        model_reset();
        #2 rst = 1'b0;
        step("t5_post_rst", 0, 0, 0, 0);

        // 6: fourth snooze (alarm back to 07:00 after reset)
        cur_h = 7; cur_m = 1; step("t6_clr", 0, 0, 0, 0);
        cur_m = 0; step("t6_ring", 0, 0, 0, 0);
        for (int n = 0; n < 3; n++) begin
            step("t6_snooze", 0, 0, 1, 0);
            repeat (60) step("t6_snz_tick", 0, 0, 0, 1);
        end
        step("t6_fourth", 0, 0, 1, 0);
        chk("t6_fourth_state", 16'(bus.state_o), LIMIT ? 16'd0 : 16'd6);

        // randomized run
        for (int i = 0; i < 3000; i++) begin
            r_mode = ($urandom_range(0, 11) == 0);
            r_inc  = ($urandom_range(0, 3) == 0);
            r_snz  = ($urandom_range(0, 9) == 0);
            r_tick = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 59) == 0) en = ~en;
            if ($urandom_range(0, 29) == 0) begin
                if ($urandom_range(0, 1) == 0) begin
                    cur_h = a_h; cur_m = a_m;
                end else begin
                    cur_h = $urandom_range(0, 23); cur_m = $urandom_range(0, 59);
                end
            end
            step("rnd", r_mode, r_inc, r_snz, r_tick);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
